// File: rtl/rx_merge.sv
// rx_merge: two-lane receive merger. Lane FIFOs feed one output FIFO
// round-robin under a RESET/INIT/IDLE/ACTIVE/ERROR state machine.
//
// Ports:
//   clk, RESET_L (sync, active low), init
//   PUSH_D0/1, DATA_IN_D0/1 : lane writes
//   POP_OUT, DATA_OUT       : output FIFO read, registered data
//   D0/D1/out _low/_high    : thresholds, latched while in INIT
//   D0/D1_AFULL, D0/D1_AEMPTY, OUT_EMPTY, OUT_AFULL, OUT_AEMPTY : flags
//   idle_out, error_out, state[2:0]
//   CNT_D0/CNT_D1           : grant counters, present only with RX_COUNT_EN
//
// A high threshold of 0 disables the matching almost-full flag, so the
// flags read AFULL=0 straight out of reset while thresholds are cleared.

module rx_merge #(
    parameter int DATA_W    = 6,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 8
) (
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              init,
    input  logic              PUSH_D0,
    input  logic              PUSH_D1,
    input  logic [DATA_W-1:0] DATA_IN_D0,
    input  logic [DATA_W-1:0] DATA_IN_D1,
    input  logic              POP_OUT,
    input  logic [4:0]        D0_low,
    input  logic [4:0]        D0_high,
    input  logic [4:0]        D1_low,
    input  logic [4:0]        D1_high,
    input  logic [4:0]        out_low,
    input  logic [4:0]        out_high,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              D0_AFULL,
    output logic              D1_AFULL,
    output logic              D0_AEMPTY,
    output logic              D1_AEMPTY,
    output logic              OUT_EMPTY,
    output logic              OUT_AFULL,
    output logic              OUT_AEMPTY,
    output logic              idle_out,
    output logic              error_out,
    output logic [2:0]        state
`ifdef RX_COUNT_EN
    ,
    output logic [7:0]        CNT_D0,
    output logic [7:0]        CNT_D1
`endif
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam logic [IAW:0]   IN_FULL  = (IAW+1)'(IN_DEPTH);
    localparam logic [OAW:0]   OUT_FULL = (OAW+1)'(OUT_DEPTH);
    localparam logic [IAW-1:0] IP_ONE   = 1;
    localparam logic [OAW-1:0] OP_ONE   = 1;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t cur, nxt;

    logic [DATA_W-1:0] lane_mem [2][IN_DEPTH];
    logic [IAW-1:0]    lane_wp  [2];
    logic [IAW-1:0]    lane_rp  [2];
    logic [IAW:0]      lane_cnt [2];
    logic [4:0]        lo_q     [2];
    logic [4:0]        hi_q     [2];

    logic [DATA_W-1:0] out_mem [OUT_DEPTH];
    logic [OAW-1:0]    out_wp, out_rp;
    logic [OAW:0]      out_cnt;
    logic [4:0]        out_lo_q, out_hi_q;
    logic              ptr;

    logic [1:0]        push, nonempty, full, grant, wr, ovf_l;
    logic [DATA_W-1:0] din [2];
    logic              can_xfer, accept, ovf, any_push, all_empty;
    logic              out_wr, out_rd;
    logic [DATA_W-1:0] xfer_word;

    assign push   = {PUSH_D1, PUSH_D0};
    assign din[0] = DATA_IN_D0;
    assign din[1] = DATA_IN_D1;

    assign D0_AFULL   = (hi_q[0] != 5'd0) && (5'(lane_cnt[0]) >= hi_q[0]);
    assign D1_AFULL   = (hi_q[1] != 5'd0) && (5'(lane_cnt[1]) >= hi_q[1]);
    assign D0_AEMPTY  = 5'(lane_cnt[0]) <= lo_q[0];
    assign D1_AEMPTY  = 5'(lane_cnt[1]) <= lo_q[1];
    assign OUT_EMPTY  = (out_cnt == '0);
    assign OUT_AFULL  = (out_hi_q != 5'd0) && (5'(out_cnt) >= out_hi_q);
    assign OUT_AEMPTY = 5'(out_cnt) <= out_lo_q;
    assign idle_out   = (cur == S_IDLE);
    assign error_out  = (cur == S_ERROR);
    assign state      = cur;

    always_comb begin
        can_xfer = (cur == S_ACTIVE) && !OUT_AFULL && (out_cnt < OUT_FULL);
        accept   = (cur == S_IDLE) || (cur == S_ACTIVE);
        for (int i = 0; i < 2; i++) begin
            nonempty[i] = (lane_cnt[i] != '0);
            full[i]     = (lane_cnt[i] == IN_FULL);
        end
        // Both lanes waiting: ptr picks; a lone lane always wins.
        grant[0] = can_xfer && nonempty[0] && (!nonempty[1] || !ptr);
        grant[1] = can_xfer && nonempty[1] && (!nonempty[0] || ptr);
        for (int i = 0; i < 2; i++) begin
            // A full lane still takes a word if it is draining this cycle.
            wr[i]    = accept && push[i] && (!full[i] || grant[i]);
            ovf_l[i] = accept && push[i] && full[i] && !grant[i];
        end
        ovf       = |ovf_l;
        any_push  = |push;
        all_empty = !(|nonempty) && (out_cnt == '0);
        out_wr    = |grant;
        out_rd    = POP_OUT && (out_cnt != '0);
        xfer_word = grant[1] ? lane_mem[1][lane_rp[1]]
                             : lane_mem[0][lane_rp[0]];
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            S_RESET:  nxt = S_INIT;
            S_INIT:   if (!init) nxt = S_IDLE;
            S_IDLE: begin
                if (ovf)                          nxt = S_ERROR;
                else if (init)                    nxt = S_INIT;
                else if (!all_empty || any_push)  nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (ovf)                          nxt = S_ERROR;
                else if (init)                    nxt = S_INIT;
                else if (all_empty && !any_push)  nxt = S_IDLE;
            end
            S_ERROR:  nxt = S_ERROR;
            default:  nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RESET_L) begin
            cur      <= S_RESET;
            ptr      <= 1'b0;
            DATA_OUT <= '0;
            out_wp   <= '0;
            out_rp   <= '0;
            out_cnt  <= '0;
            out_lo_q <= '0;
            out_hi_q <= '0;
            for (int i = 0; i < 2; i++) begin
                lane_wp[i]  <= '0;
                lane_rp[i]  <= '0;
                lane_cnt[i] <= '0;
                lo_q[i]     <= '0;
                hi_q[i]     <= '0;
            end
        end else begin
            cur <= nxt;
            if (cur == S_INIT) begin
                lo_q[0]  <= D0_low;
                hi_q[0]  <= D0_high;
                lo_q[1]  <= D1_low;
                hi_q[1]  <= D1_high;
                out_lo_q <= out_low;
                out_hi_q <= out_high;
            end
            if (out_wr) ptr <= ~ptr;
            for (int i = 0; i < 2; i++) begin
                if (wr[i]) begin
                    lane_mem[i][lane_wp[i]] <= din[i];
                    lane_wp[i] <= lane_wp[i] + IP_ONE;
                end
                if (grant[i]) lane_rp[i] <= lane_rp[i] + IP_ONE;
                lane_cnt[i] <= lane_cnt[i] + (IAW+1)'(wr[i])
                                           - (IAW+1)'(grant[i]);
            end
            if (out_wr) begin
                out_mem[out_wp] <= xfer_word;
                out_wp <= out_wp + OP_ONE;
            end
            if (out_rd) begin
                DATA_OUT <= out_mem[out_rp];
                out_rp   <= out_rp + OP_ONE;
            end
            out_cnt <= out_cnt + (OAW+1)'(out_wr) - (OAW+1)'(out_rd);
        end
    end

`ifdef RX_COUNT_EN
    always_ff @(posedge clk) begin
        if (!RESET_L || cur == S_RESET || cur == S_INIT) begin
            CNT_D0 <= '0;
            CNT_D1 <= '0;
        end else begin
            if (grant[0] && CNT_D0 != 8'hFF) CNT_D0 <= CNT_D0 + 8'd1;
            if (grant[1] && CNT_D1 != 8'hFF) CNT_D1 <= CNT_D1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_merge.sv
// tb_rx_merge: directed scenarios plus randomized traffic, checked each
// cycle against a queue-based model of the receive merger.

module tb_rx_merge;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       init = 1'b0;
    logic       p0 = 1'b0, p1 = 1'b0, pop = 1'b0;
    logic [5:0] d0 = '0, d1 = '0;
    logic [4:0] d0_lo = '0, d0_hi = '0, d1_lo = '0, d1_hi = '0;
    logic [4:0] o_lo = '0, o_hi = '0;

    logic [5:0] dout;
    logic       d0_af, d1_af, d0_ae, d1_ae, o_em, o_af, o_ae;
    logic       idle, err;
    logic [2:0] st;
`ifdef RX_COUNT_EN
    logic [7:0] cnt0, cnt1;
`endif

    rx_merge dut (
        .clk(clk), .RESET_L(rst_l), .init(init),
        .PUSH_D0(p0), .PUSH_D1(p1),
        .DATA_IN_D0(d0), .DATA_IN_D1(d1), .POP_OUT(pop),
        .D0_low(d0_lo), .D0_high(d0_hi),
        .D1_low(d1_lo), .D1_high(d1_hi),
        .out_low(o_lo), .out_high(o_hi),
        .DATA_OUT(dout),
        .D0_AFULL(d0_af), .D1_AFULL(d1_af),
        .D0_AEMPTY(d0_ae), .D1_AEMPTY(d1_ae),
        .OUT_EMPTY(o_em), .OUT_AFULL(o_af), .OUT_AEMPTY(o_ae),
        .idle_out(idle), .error_out(err), .state(st)
`ifdef RX_COUNT_EN
        , .CNT_D0(cnt0), .CNT_D1(cnt1)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [5:0] q0[$], q1[$], qo[$];
    int         ms = 0;
    int         m_lo[2], m_hi[2], m_olo, m_ohi;
    int         m_ptr, m_c0, m_c1;
    logic [5:0] m_dout = '0;
    int         s0, s1, so, nst;
    bit         can, g0, g1, acc, ovf;

    function automatic bit afull(input int n, input int hi);
        return (hi != 0) && (n >= hi);
    endfunction

    always @(posedge clk) begin
        s0 = q0.size(); s1 = q1.size(); so = qo.size();
        if (!rst_l) begin
            q0.delete(); q1.delete(); qo.delete();
            ms = 0; m_ptr = 0; m_dout = '0; m_c0 = 0; m_c1 = 0;
            m_lo = '{0, 0}; m_hi = '{0, 0}; m_olo = 0; m_ohi = 0;
        end else begin
            can = (ms == 3) && !afull(so, m_ohi) && (so < 8);
            g0  = can && s0 > 0 && (s1 == 0 || m_ptr == 0);
            g1  = can && s1 > 0 && (s0 == 0 || m_ptr == 1);
            acc = (ms == 2) || (ms == 3);
            ovf = acc && ((p0 && s0 == 4 && !g0) || (p1 && s1 == 4 && !g1));
            if (pop && so > 0) m_dout = qo.pop_front();
            if (g0) begin
                qo.push_back(q0.pop_front());
                m_ptr ^= 1;
                if (m_c0 < 255) m_c0++;
            end
            if (g1) begin
                qo.push_back(q1.pop_front());
                m_ptr ^= 1;
                if (m_c1 < 255) m_c1++;
            end
            if (acc && p0 && (s0 < 4 || g0)) q0.push_back(d0);
            if (acc && p1 && (s1 < 4 || g1)) q1.push_back(d1);
            nst = ms;
            case (ms)
                0: nst = 1;
                1: if (!init) nst = 2;
                2: if (ovf) nst = 4;
                   else if (init) nst = 1;
                   else if (s0 + s1 + so > 0 || p0 || p1) nst = 3;
                3: if (ovf) nst = 4;
                   else if (init) nst = 1;
                   else if (s0 + s1 + so == 0 && !p0 && !p1) nst = 2;
                default: nst = 4;
            endcase
            if (ms == 1) begin
                m_lo[0] = d0_lo; m_hi[0] = d0_hi;
                m_lo[1] = d1_lo; m_hi[1] = d1_hi;
                m_olo = o_lo; m_ohi = o_hi;
            end
            if (ms == 0 || ms == 1) begin m_c0 = 0; m_c1 = 0; end
            ms = nst;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(st), 32'(ms));
            check("data_out", 32'(dout), 32'(m_dout));
            check("d0_afull", 32'(d0_af), 32'(afull(q0.size(), m_hi[0])));
            check("d1_afull", 32'(d1_af), 32'(afull(q1.size(), m_hi[1])));
            check("d0_aempty", 32'(d0_ae), 32'(q0.size() <= m_lo[0]));
            check("d1_aempty", 32'(d1_ae), 32'(q1.size() <= m_lo[1]));
            check("out_empty", 32'(o_em), 32'(qo.size() == 0));
            check("out_afull", 32'(o_af), 32'(afull(qo.size(), m_ohi)));
            check("out_aempty", 32'(o_ae), 32'(qo.size() <= m_olo));
            check("idle_out", 32'(idle), 32'(ms == 2));
            check("error_out", 32'(err), 32'(ms == 4));
`ifdef RX_COUNT_EN
            check("cnt_d0", 32'(cnt0), 32'(m_c0));
            check("cnt_d1", 32'(cnt1), 32'(m_c1));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet;
        p0 = 0; p1 = 0; pop = 0; init = 0;
    endtask

    task automatic program_init(input int o_high, input int h0,
                                input int h1);
        d0_lo = 5'd1; d0_hi = 5'(h0);
        d1_lo = 5'd1; d1_hi = 5'(h1);
        o_lo = 5'd1; o_hi = 5'(o_high);
        init = 1; step;
        init = 0; step;
    endtask

    task automatic full_reset;
        quiet; rst_l = 0; step; rst_l = 1; step;
    endtask

    logic [5:0] exp3[4];

    initial begin
        exp3[0] = 6'h01; exp3[1] = 6'h21; exp3[2] = 6'h02; exp3[3] = 6'h22;

        // 1: reset
        step; chk_en = 1; step;
        check("rst_state", 32'(st), 0);
        check("rst_empty", 32'(o_em), 1);
        check("rst_dout", 32'(dout), 0);
        check("rst_err", 32'(err), 0);
        check("rst_afull", 32'(d0_af), 0);
        rst_l = 1; step;
        check("rel_state", 32'(st), 1);

        // 2: init then three D0 words through to the output
        program_init(6, 3, 4);
        check("init_idle", 32'(st), 2);
        p0 = 1;
        for (int i = 0; i < 3; i++) begin d0 = 6'(8'h11 + i); step; end
        p0 = 0; step; step; step;
        pop = 1;
        for (int i = 0; i < 3; i++) begin
            step; check("t2_pop", 32'(dout), 32'(8'h11 + i));
        end
        pop = 0; step;
        check("t2_back_idle", 32'(idle), 1);

        // 3: round robin between lanes
        full_reset;
        program_init(6, 3, 4);
        p0 = 1; p1 = 1; d0 = 6'h01; d1 = 6'h21; step;
        d0 = 6'h02; d1 = 6'h22; step;
        quiet;
        for (int i = 0; i < 4; i++) step;
        pop = 1;
        for (int i = 0; i < 4; i++) begin
            step; check("t3_rr", 32'(dout), 32'(exp3[i]));
        end
        pop = 0; step; step;

        // 4: backpressure from the output almost-full flag
        program_init(4, 3, 4);
        check("t4_idle", 32'(st), 2);
        p1 = 1;
        for (int i = 0; i < 8; i++) begin d1 = 6'(8'h20 + i); step; end
        p1 = 0; step; step;
        check("t4_out_afull", 32'(o_af), 1);
        check("t4_d1_afull", 32'(d1_af), 1);
        check("t4_active", 32'(st), 3);

        // 5: overflow on a stalled, full lane 0
        p0 = 1;
        for (int i = 0; i < 4; i++) begin d0 = 6'(8'h30 + i); step; end
        check("t5_d0_afull", 32'(d0_af), 1);
        check("t5_pre_state", 32'(st), 3);
        d0 = 6'h3F; step;
        p0 = 0;
        check("t5_error", 32'(st), 4);
        pop = 1;
        for (int i = 0; i < 4; i++) begin
            step; check("t5_drain", 32'(dout), 32'(8'h20 + i));
        end
        step;
        check("t5_empty_hold", 32'(dout), 32'h23);
        check("t5_sticky", 32'(st), 4);
        pop = 0; rst_l = 0; step;
        check("t5_reset", 32'(st), 0);
        check("t5_flushed", 32'(o_em), 1);
        rst_l = 1; step;
        check("t5_recover", 32'(st), 1);

        // randomized traffic
        program_init(6, 3, 4);
        for (int c = 0; c < 3000; c++) begin
            p0  = ($urandom_range(0, 2) == 0);
            p1  = ($urandom_range(0, 2) == 0);
            pop = ($urandom_range(0, 1) == 0);
            d0  = 6'($urandom);
            d1  = 6'($urandom);
            init = ($urandom_range(0, 149) == 0);
            if (init) begin
                d0_lo = 5'($urandom_range(0, 5));
                d0_hi = 5'($urandom_range(0, 9));
                d1_lo = 5'($urandom_range(0, 5));
                d1_hi = 5'($urandom_range(0, 9));
                o_lo  = 5'($urandom_range(0, 9));
                o_hi  = 5'($urandom_range(0, 9));
            end
            rst_l = !((ms == 4 && $urandom_range(0, 7) == 0) ||
                      $urandom_range(0, 299) == 0);
            step;
        end
        quiet; rst_l = 1;

`ifdef RX_COUNT_EN
        // 6: per-lane grant counters
        full_reset;
        program_init(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            p0 = 1; d0 = 6'(i); p1 = (i < 3); d1 = 6'(i + 8); step;
        end
        quiet;
        for (int i = 0; i < 12; i++) step;
        check("t6_cnt0", 32'(cnt0), 5);
        check("t6_cnt1", 32'(cnt1), 3);
        init = 1; step; init = 0;
        check("t6_clr0", 32'(cnt0), 0);
        check("t6_clr1", 32'(cnt1), 0);
        step;
`endif

        step;
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
